// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, SR/Cause field positions and exception codes.
// Also holds the helpers that pack the register fields into the 32-bit mfc0 read views.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int SR_IE_BIT    = 0;
    localparam int SR_EXL_BIT   = 1;
    localparam int SR_IM_LSB    = 10;
    localparam int SR_IM_MSB    = 15;
    localparam int CAUSE_BD_BIT = 31;
    localparam int CAUSE_IP_LSB = 10;
    localparam int CAUSE_IP_MSB = 15;
    localparam int CAUSE_EC_LSB = 2;
    localparam int CAUSE_EC_MSB = 6;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    function automatic logic [31:0] pack_sr(input logic [5:0] im,
                                            input logic       exl,
                                            input logic       ie);
        logic [31:0] r;
        r = '0;
        r[SR_IM_MSB:SR_IM_LSB] = im;
        r[SR_EXL_BIT]          = exl;
        r[SR_IE_BIT]           = ie;
        return r;
    endfunction

    function automatic logic [31:0] pack_cause(input logic       bd,
                                               input logic [5:0] ip,
                                               input logic [4:0] ec);
        logic [31:0] r;
        r = '0;
        r[CAUSE_BD_BIT]                = bd;
        r[CAUSE_IP_MSB:CAUSE_IP_LSB]   = ip;
        r[CAUSE_EC_MSB:CAUSE_EC_LSB]   = ec;
        return r;
    endfunction

endpackage

// File: rtl/cp0_irq_if.sv
// Pipeline <-> CP0 connection: mfc0/mtc0 access, commit-stage exception info, interrupt lines
// and the take/vector/EPC results returned to the pipeline.
interface cp0_irq_if;
  logic [4:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic [29:0] pc;
  logic        bd;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [5:0]  hwint;
  logic        eret;
  logic        take;
  logic [31:0] vec_out;
  logic [31:0] epc_out;

  modport master (
    output addr, we, din, pc, bd, exc_valid, exc_code, hwint, eret,
    input  dout, take, vec_out, epc_out
  );

  modport slave (
    input  addr, we, din, pc, bd, exc_valid, exc_code, hwint, eret,
    output dout, take, vec_out, epc_out
  );
endinterface

// File: rtl/cp0_int_arb.sv
// Combinational request/priority logic: interrupts beat synchronous exceptions,
// and everything is suppressed while EXL is set.
module cp0_int_arb
  import cp0_pkg::*;
(
  input  logic       ie_i,
  input  logic       exl_i,
  input  logic [5:0] im_i,
  input  logic [5:0] hwint_i,
  input  logic       exc_valid_i,
  input  logic [4:0] exc_code_i,
  output logic       take_o,
  output logic [4:0] code_o
);

  logic [5:0] pend;
  logic       int_req;
  logic       exc_req;

  // Live lines are used so a level asserted this cycle is taken this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_mask
      assign pend[gi] = hwint_i[gi] & im_i[gi];
    end
  endgenerate

  assign int_req = ie_i & ~exl_i & (|pend);
  assign exc_req = exc_valid_i & ~exl_i;
  assign take_o  = int_req | exc_req;
  assign code_o  = int_req ? EXC_INT : exc_code_i;

endmodule

// File: rtl/cp0_irq.sv
// CP0 SR/Cause/EPC/PRID register file with exception/interrupt entry and eret return.
// EPC is stored as a word address; its low two bits always read as zero.
module cp0_irq
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID    = 32'h2020_0001,
  parameter logic [31:0] HANDLER = 32'h0000_4180
) (
  input  logic         clk,
  input  logic         rst_n,
  cp0_irq_if.slave     bus
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  ec_q, ec_d;
  logic [29:0] epc_q, epc_d;

  logic        take_arb;
  logic [4:0]  code_arb;
  logic        unused_din_bits;

  assign unused_din_bits = ^bus.din[1:0];

  cp0_int_arb u_arb (
    .ie_i        (ie_q),
    .exl_i       (exl_q),
    .im_i        (im_q),
    .hwint_i     (bus.hwint),
    .exc_valid_i (bus.exc_valid),
    .exc_code_i  (bus.exc_code),
    .take_o      (take_arb),
    .code_o      (code_arb)
  );

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ip_d  = bus.hwint;
    ec_d  = ec_q;
    epc_d = epc_q;
    if (take_arb) begin
      // Entry wins over any mtc0 in the same cycle; a delay-slot fault restarts at the branch.
      exl_d = 1'b1;
      ec_d  = code_arb;
      bd_d  = bus.bd;
      epc_d = bus.bd ? (bus.pc - 30'd1) : bus.pc;
    end else begin
      if (bus.we) begin
        case (bus.addr)
          REG_SR: begin
            im_d  = bus.din[SR_IM_MSB:SR_IM_LSB];
            exl_d = bus.din[SR_EXL_BIT];
            ie_d  = bus.din[SR_IE_BIT];
          end
          REG_EPC: epc_d = bus.din[31:2];
          default: ;
        endcase
      end
      if (bus.eret) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      ec_q  <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      ec_q  <= ec_d;
      epc_q <= epc_d;
    end
  end

  always_comb begin
    bus.dout = '0;
    case (bus.addr)
      REG_SR:    bus.dout = pack_sr(im_q, exl_q, ie_q);
      REG_CAUSE: bus.dout = pack_cause(bd_q, ip_q, ec_q);
      REG_EPC:   bus.dout = {epc_q, 2'b00};
      REG_PRID:  bus.dout = PRID;
      default:   bus.dout = '0;
    endcase
  end

  // A pending synchronous exception must not flush the pipeline while held in reset.
  assign bus.take    = take_arb & rst_n;
  assign bus.vec_out = HANDLER;
  assign bus.epc_out = {epc_q, 2'b00};

endmodule
